// File: rtl/traffic_input_conditioner.sv
// Input front end for the intersection light controller: two-flop
// synchronisers and debouncers for the two vehicle sensors and the
// active-low pedestrian button, a sticky pedestrian request, and a
// restartable 1-second timebase with a saturating seconds count.
module traffic_input_conditioner #(
  parameter int CLK_DIV         = 25000000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SEC_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             la_rue_raw,
  input  logic             orchard_raw,
  input  logic             ped_button_n,
  input  logic             ped_clear,
  input  logic             tick_restart,
  output logic             la_rue_sensor,
  output logic             orchard_sensor,
  output logic             ped_press,
  output logic             ped_request,
  output logic             sec_tick,
  output logic [SEC_W-1:0] sec_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Channel order {button_n, orchard, la_rue}; the button idles high (released).
  localparam logic [2:0] CH_IDLE = 3'b100;
  localparam int BTN = 2;

  logic [2:0]       raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       stable_p2;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       flip;
  logic             press_evt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
    return (v == {SEC_W{1'b1}}) ? v : v + SEC_W'(1);
  endfunction

  assign raw = {ped_button_n, orchard_raw, la_rue_raw};

  // Stage p0/p1: two-flop synchroniser, no logic between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= CH_IDLE;
      sync_p1 <= CH_IDLE;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A channel flips once the synced value has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    flip = '0;
    for (int c = 0; c < 3; c++) begin
      flip[c] = (sync_p1[c] != stable_p2[c]) && (db_cnt[c] == CNT_LAST);
    end
  end

  // Released (1) -> pressed (0) on the debounced button.
  assign press_evt = flip[BTN] & stable_p2[BTN];

  // Stage p2: debounce counters and stable values; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_p2 <= CH_IDLE;
      for (int c = 0; c < 3; c++) begin
        db_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if ((sync_p1[c] == stable_p2[c]) || flip[c]) begin
          db_cnt[c] <= '0;
        end else begin
          db_cnt[c] <= db_cnt[c] + CNT_W'(1);
        end
      end
      stable_p2 <= stable_p2 ^ flip;
    end
  end

  assign la_rue_sensor  = stable_p2[0];
  assign orchard_sensor = stable_p2[1];

  // Press pulse and sticky request; a press coinciding with a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_press   <= 1'b0;
      ped_request <= 1'b0;
    end else begin
      ped_press   <= press_evt;
      ped_request <= press_evt | (ped_request & ~ped_clear);
    end
  end

  assign div_wrap = (div_cnt == DIV_LAST);

  // Timebase: restart dominates a coincident wrap and suppresses its tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      sec_tick  <= 1'b0;
      sec_count <= '0;
    end else if (tick_restart) begin
      div_cnt   <= '0;
      sec_tick  <= 1'b0;
      sec_count <= '0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      sec_tick  <= 1'b1;
      sec_count <= sat_inc(sec_count);
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
      sec_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Bench for traffic_input_conditioner: reset vector table, hand-written
// corner sequences, and a randomized run, all checked every cycle against a
// behavioural model (sample windows for debounce, elapsed-cycle arithmetic
// for the timebase).
module tb_traffic_input_conditioner;

  localparam int CLK_DIV = 10;
  localparam int DB      = 4;
  localparam int SEC_W   = 4;
  localparam int SEC_MAX = 15;

  logic             clk;
  logic             reset;
  logic             la_rue_raw;
  logic             orchard_raw;
  logic             ped_button_n;
  logic             ped_clear;
  logic             tick_restart;
  logic             la_rue_sensor;
  logic             orchard_sensor;
  logic             ped_press;
  logic             ped_request;
  logic             sec_tick;
  logic [SEC_W-1:0] sec_count;

  traffic_input_conditioner #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYCLES(DB),
    .SEC_W(SEC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .la_rue_raw(la_rue_raw),
    .orchard_raw(orchard_raw),
    .ped_button_n(ped_button_n),
    .ped_clear(ped_clear),
    .tick_restart(tick_restart),
    .la_rue_sensor(la_rue_sensor),
    .orchard_sensor(orchard_sensor),
    .ped_press(ped_press),
    .ped_request(ped_request),
    .sec_tick(sec_tick),
    .sec_count(sec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2:0]    sq [$];
  logic [DB-1:0] hist [3];
  logic [2:0]    m_stable;
  logic          m_press;
  logic          m_req;
  int            m_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_edge();
    logic [2:0] raw;
    logic [2:0] syn;
    logic       was_pressed;
    raw = {ped_button_n, orchard_raw, la_rue_raw};
    if (reset) begin
      sq.delete();
      sq.push_back(3'b100);
      sq.push_back(3'b100);
      m_stable = 3'b100;
      for (int c = 0; c < 3; c++) hist[c] = {DB{m_stable[c]}};
      m_press = 1'b0;
      m_req   = 1'b0;
      m_t     = 0;
    end else begin
      syn = sq.pop_front();
      sq.push_back(raw);
      was_pressed = ~m_stable[2];
      for (int c = 0; c < 3; c++) begin
        hist[c] = {hist[c][DB-2:0], syn[c]};
        if (hist[c] == {DB{~m_stable[c]}}) m_stable[c] = ~m_stable[c];
      end
      m_press = !was_pressed && !m_stable[2];
      m_req   = m_press | (m_req & ~ped_clear);
      m_t     = tick_restart ? 0 : m_t + 1;
    end
  endtask

  task automatic check_model();
    int secs;
    secs = m_t / CLK_DIV;
    if (secs > SEC_MAX) secs = SEC_MAX;
    chk("la_rue_sensor",  la_rue_sensor,  m_stable[0]);
    chk("orchard_sensor", orchard_sensor, m_stable[1]);
    chk("ped_press",      ped_press,      m_press);
    chk("ped_request",    ped_request,    m_req);
    chk("sec_tick",       sec_tick,       (m_t != 0 && m_t % CLK_DIV == 0) ? 1 : 0);
    chk("sec_count",      sec_count,      secs);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic       rst;
    logic       la;
    logic       btn_n;
    logic       e_la;
    logic       e_pr;
    logic       e_rq;
    logic       e_tk;
    logic [3:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic la, input logic btn_n,
                              input logic e_la, input logic e_pr, input logic e_rq,
                              input logic e_tk, input logic [3:0] e_cnt);
    vec_t v;
    v.rst = rst; v.la = la; v.btn_n = btn_n;
    v.e_la = e_la; v.e_pr = e_pr; v.e_rq = e_rq; v.e_tk = e_tk; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv [14];
    int   presses;
    int   rise_at;
    int   fall_at;
    int   tick_n;
    int   last_tick;
    int   first_tick;

    reset = 1'b1; la_rue_raw = 1'b1; orchard_raw = 1'b0; ped_button_n = 1'b0;
    ped_clear = 1'b0; tick_restart = 1'b0;

    // Reset held 3 edges with la_rue high and button pressed, then released.
    for (int i = 0; i < 3; i++) tv[i] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 3; i < 8; i++) tv[i] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tv[8] = mk(0, 1, 0, 1, 1, 1, 0, 0);
    for (int i = 9; i < 12; i++) tv[i] = mk(0, 1, 0, 1, 0, 1, 0, 0);
    tv[12] = mk(0, 1, 0, 1, 0, 1, 1, 1);
    tv[13] = mk(0, 1, 0, 1, 0, 1, 0, 1);

    for (int i = 0; i < 14; i++) begin
      reset = tv[i].rst; la_rue_raw = tv[i].la; ped_button_n = tv[i].btn_n;
      step();
      chk($sformatf("vec%0d_la", i),   la_rue_sensor,  tv[i].e_la);
      chk($sformatf("vec%0d_orch", i), orchard_sensor, 0);
      chk($sformatf("vec%0d_press", i), ped_press,     tv[i].e_pr);
      chk($sformatf("vec%0d_req", i),  ped_request,    tv[i].e_rq);
      chk($sformatf("vec%0d_tick", i), sec_tick,       tv[i].e_tk);
      chk($sformatf("vec%0d_cnt", i),  sec_count,      tv[i].e_cnt);
    end

    // Settle: release everything and clear the request.
    ped_button_n = 1'b1; la_rue_raw = 1'b0; ped_clear = 1'b1;
    idle(10);
    ped_clear = 1'b0;

    // Glitch rejection: 3-cycle pulse must not reach orchard_sensor.
    orchard_raw = 1'b1;
    idle(3);
    orchard_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_orch", orchard_sensor, 0);
    end

    // 5-cycle pulse: rise and fall each visible on the 6th edge.
    rise_at = 0; fall_at = 0;
    for (int i = 1; i <= 20; i++) begin
      orchard_raw = (i <= 5);
      step();
      if (rise_at == 0 && orchard_sensor) rise_at = i;
      if (rise_at != 0 && fall_at == 0 && !orchard_sensor) fall_at = i;
    end
    chk("orch_rise_latency", rise_at, 6);
    chk("orch_fall_latency", fall_at - 5, 6);

    // Pedestrian: long hold yields one pulse, request sticks.
    presses = 0;
    ped_button_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ped_press) presses++;
    end
    chk("hold_press_count", presses, 1);
    chk("hold_request", ped_request, 1);
    ped_button_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ped_press) presses++;
    end
    chk("release_no_pulse", presses, 1);
    chk("request_held", ped_request, 1);
    ped_clear = 1'b1;
    step();
    ped_clear = 1'b0;
    chk("request_cleared", ped_request, 0);

    // Second press with ped_clear on the very edge its pulse is asserted.
    ped_button_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      ped_clear = (i == 6);
      step();
    end
    ped_clear = 1'b0;
    chk("coincide_press", ped_press, 1);
    chk("coincide_request", ped_request, 1);
    step();
    chk("coincide_request_after", ped_request, 1);
    ped_button_n = 1'b1;
    idle(8);

    // Free-run timebase after reset: ticks 10 apart with counts 1,2,3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick_n = 0; last_tick = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (sec_tick) begin
        tick_n++;
        chk("tick_spacing", i - last_tick, CLK_DIV);
        chk("tick_count_value", sec_count, tick_n);
        last_tick = i;
      end
    end
    chk("freerun_ticks", tick_n, 3);

    // Restart exactly when the divider sits at its last count.
    for (int i = 0; i < 20; i++) begin
      if (m_t % CLK_DIV == CLK_DIV - 1) break;
      step();
    end
    chk("restart_aligned", m_t % CLK_DIV, CLK_DIV - 1);
    tick_restart = 1'b1;
    step();
    tick_restart = 1'b0;
    chk("restart_no_tick", sec_tick, 0);
    chk("restart_count", sec_count, 0);
    first_tick = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (first_tick == 0 && sec_tick) first_tick = i;
    end
    chk("restart_first_tick", first_tick, CLK_DIV);

    // Saturation over 200 cycles.
    tick_restart = 1'b1;
    step();
    tick_restart = 1'b0;
    tick_n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (sec_tick) tick_n++;
      if (i == 160) chk("sat_reached", sec_count, SEC_MAX);
    end
    chk("sat_hold", sec_count, SEC_MAX);
    chk("sat_tick_count", tick_n, 20);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) la_rue_raw = ~la_rue_raw;
      if ($urandom_range(0, 5) == 0) orchard_raw = ~orchard_raw;
      if ($urandom_range(0, 7) == 0) ped_button_n = ~ped_button_n;
      ped_clear    = ($urandom_range(0, 9) == 0);
      tick_restart = ($urandom_range(0, 59) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; ped_clear = 1'b0; tick_restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_input_conditioner.md
Name: traffic_input_conditioner

Overview:
Front-end stage that feeds the intersection light controller. It synchronises and debounces the La Rue and Orchard vehicle sensors and the active-low pedestrian push-button, and holds a sticky pedestrian request until the controller clears it. It also generates the 1-second timebase and a saturating seconds count, which the controller restarts on every state transition.

Parameters:
CLK_DIV, 25000000, clock cycles per sec_tick (25 MHz board clock); legal range >= 2
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes (10 ms); legal range >= 1
SEC_W, 8, width of sec_count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
la_rue_raw  input  1  raw La Rue vehicle sensor, active-high, asynchronous
orchard_raw  input  1  raw Orchard vehicle sensor, active-high, asynchronous
ped_button_n  input  1  raw pedestrian button, active-low, asynchronous
ped_clear  input  1  one-cycle strobe from the controller that clears ped_request (pedestrian phase served)
tick_restart  input  1  one-cycle strobe from the controller that restarts the timebase (state change)
la_rue_sensor  output  1  debounced La Rue sensor, active-high
orchard_sensor  output  1  debounced Orchard sensor, active-high
ped_press  output  1  one-cycle pulse on each debounced button press
ped_request  output  1  sticky pedestrian request
sec_tick  output  1  one-cycle pulse once per CLK_DIV cycles
sec_count  output  SEC_W  whole seconds since the last tick_restart; saturates

Behaviour:
- One clock domain. All state updates on posedge clk. Reset is synchronous and active-high: reset = 1 at a posedge loads reset values, and it overrides every other input.
- Reset values:
  - Outputs: all outputs 0.
  - Synchroniser flops: 0 for the sensors, 1 for the button (released).
  - Debounce counters, divider and sec_count: 0.
  - Debounced button state: released.
- Synchroniser: 2 flops per raw input. No logic sits between the two stages.
- Debounce, identical per channel:
  - Each channel holds a stable value and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - If synced == stable, the counter is cleared.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, stable takes synced and the counter clears. If not, the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never reaches the output. Any return to the stable value restarts the count.
  - Latency: a raw change that is stable from before posedge k shows on the output after posedge k+1+DEBOUNCE_CYCLES, which is DEBOUNCE_CYCLES+2 edges.
- Outputs from the debounced values:
  - la_rue_sensor and orchard_sensor are the stable values, registered.
  - Button: pressed = NOT stable_button_n.
- ped_press: registered. High for exactly the one cycle after the debounced button goes released -> pressed. Release produces no pulse. Holding the button produces one pulse only.
- ped_request, evaluated each cycle:
  - Next value = ped_press OR (ped_request AND NOT ped_clear). The set term uses the ped_press value being asserted on that same edge.
  - If ped_clear and a new press pulse coincide, ped_request ends set, so the press is not lost.
  - Repeated presses while the request is already set have no further effect.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - sec_tick is registered and high for the one cycle following the edge at which the divider wraps from CLK_DIV-1. The period is exactly CLK_DIV cycles.
  - tick_restart: the divider loads 0 and no sec_tick is produced from that edge, even if the divider was at CLK_DIV-1. Restart wins.
  - After a restart, the first sec_tick asserts CLK_DIV cycles later.
- sec_count:
  - On tick_restart it loads 0.
  - Otherwise it increments by 1 on each edge where the divider wraps. sec_count and sec_tick update together.
  - It saturates at 2^SEC_W-1 and never wraps.
- No handshake: ped_clear and tick_restart are plain strobes. Holding either high for several cycles is legal and keeps the request clear or the timebase at 0 respectively.

Test Plan (CLK_DIV=10, DEBOUNCE_CYCLES=4, SEC_W=4 unless noted):
- Reset: hold reset 3 cycles with la_rue_raw=1 and ped_button_n=0 -> all outputs 0 during reset. After release, la_rue_sensor rises 6 edges after the first non-reset edge, and ped_press pulses exactly once.
- Glitch rejection: orchard_raw high for 3 cycles, then low -> orchard_sensor stays 0. Then high for 5 cycles -> orchard_sensor = 1, 6 edges after the rise. It returns to 0, 6 edges after the fall.
- Pedestrian latch: press held 20 cycles -> one ped_press pulse, and ped_request = 1 until ped_clear. ped_clear asserted on the same edge as a second press pulse -> ped_request remains 1.
- Timebase: free-run 35 cycles after reset -> sec_tick pulses exactly 10 cycles apart (3 pulses), and sec_count = 1, 2, 3 on those cycles.
- Restart boundary: assert tick_restart on the cycle where the divider is at 9 -> no sec_tick, sec_count = 0, and the next sec_tick comes 10 cycles later.
- Saturation: run 200 cycles with no restart -> sec_count reaches 15 and holds at 15, while sec_tick keeps pulsing every 10 cycles.
